// File: rtl/led_status_pkg.sv
// Shared types and constants for the status-LED scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state_e (scheduler FSM states), TIMER_W (phase timer width).
package led_status_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int TIMER_W = 32;

endpackage

// File: rtl/led_status_sched_arb.sv
// Round-robin pick among status sources; pointer holds the last winner.
// Latency: winner/valid are combinational from req; pointer updates one cycle after grant_en.
// Backpressure: none; a pending request simply waits for its turn.
//
// Ports: clk, reset (sync, active-high), req[NUM_REQ], grant_en (commit the
//        current pick), winner[NUM_REQ] (one-hot), valid (some request pending).
module led_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_idx;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int off);
        return PTR_W'((int'(p) + off) % NUM_REQ);
    endfunction

    // Search starts just after the last winner and wraps, so the last winner
    // is considered last (off == NUM_REQ lands back on the pointer).
    always_comb begin
        valid   = 1'b0;
        win_idx = ptr_q;
        winner  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!valid && req[wrap_idx(ptr_q, off)]) begin
                valid   = 1'b1;
                win_idx = wrap_idx(ptr_q, off);
            end
        end
        if (valid) begin
            winner[win_idx] = 1'b1;
        end
    end

    // Reset value NUM_REQ-1 gives index 0 top priority for the first grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else if (grant_en && valid) begin
            ptr_q <= win_idx;
        end
    end

endmodule

// File: rtl/led_status_sched.sv
// Shares one board LED among NUM_REQ status sources: blinks the granted source's code, then a dark gap.
// Latency: grant/led one cycle after a request is seen in IDLE; frame = (2*code + GAP_MULT)*HALF_PERIOD cycles.
// Backpressure: sources hold req_i until their ack_o pulse; at most one frame in flight.
//
// Ports: clk, reset (sync, active-high), req_i[NUM_REQ], code_i[NUM_REQ*CODE_W]
//        (slice i = code of source i), grant_o (one-hot, displayed source),
//        ack_o (pulse on last GAP cycle), busy_o (not IDLE), led (registered).
module led_status_sched
    import led_status_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CODE_W      = 4,
    parameter int HALF_PERIOD = 10000000,
    parameter int GAP_MULT    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*CODE_W-1:0] code_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      busy_o,
    output logic                      led
);

    localparam logic [TIMER_W-1:0] HP_LAST  = TIMER_W'(HALF_PERIOD) - TIMER_W'(1);
    // 32-bit product; the integrator keeps GAP_MULT*HALF_PERIOD below 2^32.
    localparam logic [TIMER_W-1:0] GAP_LEN  = TIMER_W'(GAP_MULT) * TIMER_W'(HALF_PERIOD);
    localparam logic [TIMER_W-1:0] GAP_LAST = GAP_LEN - TIMER_W'(1);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CODE_W-1:0]   blinks_q, blinks_d;
    logic [CODE_W-1:0]   code_sel;
    logic [NUM_REQ-1:0]  winner;
    logic [NUM_REQ-1:0]  grant_d;
    logic [NUM_REQ-1:0]  ack_d;
    logic                arb_vld;
    logic                grant_en;

    assign grant_en = (state_q == IDLE);

    led_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_i),
        .grant_en (grant_en),
        .winner   (winner),
        .valid    (arb_vld)
    );

    // Code of the current winner; only consumed in IDLE, so later code_i
    // changes never reach a frame in progress.
    always_comb begin
        code_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                code_sel = code_i[i*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        blinks_d = blinks_q;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    blinks_d = code_sel;
                    state_d  = (code_sel == '0) ? GAP : ON;
                end
            end
            ON: begin
                if (timer_q == HP_LAST) begin
                    state_d  = OFF;
                    blinks_d = blinks_q - CODE_W'(1);
                end
            end
            OFF: begin
                if (timer_q == HP_LAST) begin
                    state_d = (blinks_q != '0) ? ON : GAP;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timer restarts on every state entry and idles at zero.
        if (state_d != state_q || state_d == IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        if (state_d == IDLE) begin
            grant_d = '0;
        end else if (state_q == IDLE) begin
            grant_d = winner;
        end else begin
            grant_d = grant_o;
        end

        // Outputs are registered from next-state values so the ack lands on
        // the final GAP cycle itself rather than one cycle late.
        ack_d = (state_d == GAP && timer_d == GAP_LAST) ? grant_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            blinks_q <= '0;
            grant_o  <= '0;
            ack_o    <= '0;
            busy_o   <= 1'b0;
            led      <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            blinks_q <= blinks_d;
            grant_o  <= grant_d;
            ack_o    <= ack_d;
            busy_o   <= (state_d != IDLE);
            led      <= (state_d == ON);
        end
    end

endmodule

// File: tb/tb_led_status_sched.sv
module tb_led_status_sched;

    localparam int HP = 4;
    localparam int GM = 2;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [3:0] grant;
        logic [3:0] ack;
    } obs_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  grant_o, ack_o;
    logic        busy_o, led;

    logic [3:0]  lreq;
    logic [15:0] lcode;
    logic [3:0]  l_grant, l_ack;
    logic        l_busy, l_led;

    int   checks;
    int   failures;
    obs_t exp_q[$];

    led_status_sched #(
        .NUM_REQ(4), .CODE_W(4), .HALF_PERIOD(HP), .GAP_MULT(GM)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req), .code_i(code),
        .grant_o(grant_o), .ack_o(ack_o), .busy_o(busy_o), .led(led)
    );

    led_status_sched dut_long (
        .clk(clk), .reset(reset), .req_i(lreq), .code_i(lcode),
        .grant_o(l_grant), .ack_o(l_ack), .busy_o(l_busy), .led(l_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle trace of one frame: code x (HP on, HP off), then GM*HP dark, ack on last.
    task automatic push_frame(input int c, input logic [3:0] g);
        obs_t e;
        for (int b = 0; b < c; b++) begin
            for (int k = 0; k < 2*HP; k++) begin
                e = '{led: (k < HP), busy: 1'b1, grant: g, ack: 4'b0000};
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < GM*HP; k++) begin
            e = '{led: 1'b0, busy: 1'b1, grant: g, ack: (k == GM*HP-1) ? g : 4'b0000};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle();
        exp_q.push_back('{led: 1'b0, busy: 1'b0, grant: 4'b0000, ack: 4'b0000});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        code  = '0;
        lreq  = '0;
        lcode = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b want=0", led); end
        checks++;
        if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant_o); end
        checks++;
        if (ack_o !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b want=0000", ack_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        obs_t o, e;
        int   frames;
        logic rearm;
        frames = 0;
        rearm  = 1'b0;
        @(negedge clk);
        code = 16'h1111;
        req  = 4'b1011;
        push_frame(1, 4'b0001); push_idle();
        push_frame(1, 4'b0010); push_idle();
        push_frame(1, 4'b1000); push_idle();
        push_frame(1, 4'b0001); push_idle();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rr_trace got(led,busy,grant,ack)=%b want=%b", o, e);
            end
            if (rearm) begin
                req   = 4'b1011;
                rearm = 1'b0;
            end
            if (ack_o != 4'b0000) begin
                frames++;
                if (frames >= 4) begin
                    req = 4'b0000;
                end else begin
                    req   = req & ~ack_o;
                    rearm = 1'b1;
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        obs_t o, e;
        @(negedge clk);
        code[3:0] = 4'd3;
        req       = 4'b0001;
        push_frame(3, 4'b0001);
        push_idle();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_trace got(led,busy,grant,ack)=%b want=%b", o, e);
            end
            if (ack_o != 4'b0000) req = req & ~ack_o;
        end
        req = 4'b0000;
    endtask

    task automatic test_code_zero();
        obs_t o, e;
        @(negedge clk);
        code[11:8] = 4'd0;
        req        = 4'b0100;
        push_frame(0, 4'b0100);
        push_idle();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL code_zero_trace got(led,busy,grant,ack)=%b want=%b", o, e);
            end
            if (ack_o != 4'b0000) req = req & ~ack_o;
        end
        req = 4'b0000;
    endtask

    task automatic test_midframe();
        obs_t o, e;
        int   i;
        i = 0;
        @(negedge clk);
        code[3:0] = 4'd2;
        req       = 4'b0001;
        push_frame(2, 4'b0001);
        push_idle();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midframe_trace idx=%0d got(led,busy,grant,ack)=%b want=%b", i, o, e);
            end
            if (i == 1) code[3:0] = 4'd5;
            if (i == 5) req = 4'b0000;
            i++;
        end
        code[3:0] = 4'd2;
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        @(negedge clk);
        code[7:4] = 4'd3;
        code[3:0] = 4'd2;
        req       = 4'b0010;
        push_frame(3, 4'b0010);
        // Second ON spans trace indices 8..11; reset lands at index 9.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_pre idx=%0d got(led,busy,grant,ack)=%b want=%b", i, o, e);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        push_idle();
        @(negedge clk);
        o = obs_t'({led, busy_o, grant_o, ack_o});
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid_outputs got(led,busy,grant,ack)=%b want=%b", o, e);
        end
        checks++;
        if (dut.timer_q !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_timer got=%0d want=0", dut.timer_q);
        end
        checks++;
        if (dut.blinks_q !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_blinks got=%0d want=0", dut.blinks_q);
        end
        reset = 1'b0;
        req   = 4'b1001;
        // Pointer back at NUM_REQ-1: index 0 beats index 3.
        push_frame(2, 4'b0001);
        push_idle();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            o = obs_t'({led, busy_o, grant_o, ack_o});
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_after got(led,busy,grant,ack)=%b want=%b", o, e);
            end
            if (ack_o != 4'b0000) req = 4'b0000;
        end
        req = 4'b0000;
    endtask

    task automatic test_long_phase();
        @(negedge clk);
        lcode[3:0] = 4'd1;
        lreq       = 4'b0001;
        @(negedge clk);
        checks++;
        if (l_led !== 1'b1 || l_grant !== 4'b0001 || l_busy !== 1'b1 || l_ack !== 4'b0000) begin
            failures++;
            $display("FAIL long_start got led=%b grant=%b busy=%b ack=%b want 1 0001 1 0000",
                     l_led, l_grant, l_busy, l_ack);
        end
        lreq = 4'b0000;
        force dut_long.timer_q = 32'd9999990;
        #1;
        release dut_long.timer_q;
        for (int k = 9999991; k <= 9999999; k++) begin
            @(negedge clk);
            checks++;
            if (dut_long.timer_q !== 32'(k) || l_led !== 1'b1) begin
                failures++;
                $display("FAIL long_on timer=%0d led=%b want timer=%0d led=1", dut_long.timer_q, l_led, k);
            end
        end
        @(negedge clk);
        checks++;
        if (l_led !== 1'b0 || dut_long.timer_q !== 32'd0 || l_busy !== 1'b1) begin
            failures++;
            $display("FAIL long_off led=%b timer=%0d busy=%b want led=0 timer=0 busy=1",
                     l_led, dut_long.timer_q, l_busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_code_zero();
        test_midframe();
        test_reset_mid();
        test_long_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_sched.md
# led_status_sched

Status-LED scheduler for the FPGA top level: shares one board LED among `NUM_REQ` status sources (e.g. boot done, clock-lock, error) by granting them round-robin. The granted source's identity is shown as a burst of `code` blinks followed by a dark gap. It sits beside the clock-heartbeat logic in the FPGA wrapper and drives the pad-level LED signal directly.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `CODE_W`, default 4: width of each requester's blink code.
- `HALF_PERIOD`, default 10000000: clock cycles per blink ON phase and per OFF phase. Must be ≥ 2.
- `GAP_MULT`, default 4: length of the dark gap after a burst, in units of `HALF_PERIOD`. Must be ≥ 1.
- `clk`  in  1: the single clock.
- `reset`  in  1: reset, synchronous and active-high.
- `req_i`  in  NUM_REQ: per-source request level.
- `code_i`  in  NUM_REQ*CODE_W: per-source blink count. Slice i is `[i*CODE_W +: CODE_W]`.
- `grant_o`  out  NUM_REQ: one-hot, marks the source currently being displayed.
- `ack_o`  out  NUM_REQ: one-cycle pulse to the displayed source when its frame completes.
- `busy_o`  out  1: high whenever the FSM is not in IDLE.
- `led`  out  1: registered LED drive.

## Operation
- FSM states: IDLE, ON, OFF, GAP.
- **IDLE**
  - If any `req_i` bit is high, the round-robin arbiter picks a winner.
  - The winner's code is latched into `blinks_left` and the winner is latched into `grant_o`.
  - Next state: ON, or GAP if the latched code is 0.
  - If no request is pending, stay in IDLE with `led` = 0.
- **ON**
  - `led` = 1 for exactly `HALF_PERIOD` cycles, then go to OFF and decrement `blinks_left`.
- **OFF**
  - `led` = 0 for `HALF_PERIOD` cycles.
  - Then go to ON if `blinks_left` ≠ 0, else go to GAP.
- **GAP**
  - `led` = 0 for `GAP_MULT*HALF_PERIOD` cycles.
  - On the last GAP cycle, `ack_o[winner]` = 1, then return to IDLE.
- **Phase timer**
  - 32-bit, reset to 0 on every state entry, counts up.
  - A phase ends when the timer reaches its length − 1.
  - The GAP length is computed as a 32-bit product; the user must keep it below 2^32.
- **Handshake**
  - A source holds `req_i` until it sees its `ack_o`.
  - `code_i` is sampled only at grant; changes during a frame are ignored.
  - Dropping `req_i` mid-frame does not abort the frame. The frame completes and `ack_o` still pulses.
- **Round-robin arbitration**
  - A pointer holds the last winner.
  - Priority search starts at pointer+1 and wraps modulo `NUM_REQ`.
  - The pointer updates only on grant.
  - After reset the pointer is `NUM_REQ-1`, so index 0 has top priority.
- **Reset**
  - May occur at any cycle, including mid-frame.
  - Next cycle: state IDLE, `led`=0, `grant_o`=0, `ack_o`=0, `busy_o`=0, timer=0, `blinks_left`=0, pointer=`NUM_REQ-1`.
  - No ack is issued for an aborted frame.

## Timing
- All outputs are registered.
- Request `req_i[k]` sampled high in IDLE at cycle t:
  - At t+1: state ON, `led`=1, `grant_o`=1<<k, `busy_o`=1.
  - With code 0, t+1 is GAP instead, with `led`=0.
- Frame length from t+1 is `(2*code*HALF_PERIOD + GAP_MULT*HALF_PERIOD)` cycles.
- `ack_o` is high during the final GAP cycle. `grant_o` and `busy_o` clear on the following cycle (IDLE).
- Minimum spacing between frames: one IDLE cycle. A back-to-back request is granted at the end of that IDLE cycle, so its first `led`=1 appears 2 cycles after the previous `ack_o`.
- Simultaneous requests are resolved purely by the round-robin pointer. No source can be granted twice while another source's request stays pending.

## Structure
- Package `led_status_pkg`:
  - `state_e` enum (IDLE/ON/OFF/GAP).
  - `TIMER_W = 32` localparam.
- Sub-module `led_rr_arb`:
  - Combinational round-robin pick over `NUM_REQ` bits from the pointer.
  - Outputs a one-hot winner and a `valid` flag.
  - The pointer register lives in `led_rr_arb` and updates on a `grant_en` input.
- Top level: FSM, phase timer, `blinks_left` counter, output registers.

## Test plan
All scenarios use `HALF_PERIOD=4`, `GAP_MULT=2`, `NUM_REQ=4` unless stated.
- **Single frame:** `req_i`=0001, code0=3. Required:
  - `led` = 1111 0000 repeated 3×, then 8 zeros.
  - `ack_o`=0001 on cycle 32 after grant.
  - `grant_o`=0001 throughout the frame.
- **Round-robin order:** `req_i`=1011 held, all codes 1. Required:
  - Grants in order 0001, 0010, 1000, 0001.
  - Each ack drops the matching req bit until it is re-raised.
- **Code zero:** code2=0, `req_i`=0100. Required:
  - `led` stays 0.
  - GAP lasts 8 cycles, then `ack_o`=0100.
- **Mid-frame changes:**
  - Change code0 from 2 to 5 during the first ON. Required: exactly 2 blinks.
  - Drop `req_i` mid-OFF. Required: the frame still completes and acks.
- **Reset mid-frame:** assert `reset` during the second ON of a 3-blink frame. Required:
  - Next cycle all outputs are 0 and no ack is issued.
  - Index 0 wins first after release.
- **Long phases:** default `HALF_PERIOD=10000000` with a forced-timer check. Required: no overflow, and the ON phase ends at timer 9999999.
